if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'hBFC0_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have input clk, 1 bit: the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have input stall_i, 1 bit: the decode stage cannot accept a new instruction this cycle.
REQ-005 The block SHALL have input branch_flag_i, 1 bit: decode resolved a taken branch/jump this cycle.
REQ-006 The block SHALL have input branch_target_i, 32 bits: the taken-branch target address.
REQ-007 The block SHALL have output imem_req_o, 1 bit: instruction memory read request.
REQ-008 The block SHALL have output imem_addr_o, 32 bits: the word address of the request.
REQ-009 The block SHALL have input imem_ack_i, 1 bit: read data valid; may be asserted in the same cycle as the request.
REQ-010 The block SHALL have input imem_rdata_i, 32 bits: the instruction word.
REQ-011 The block SHALL have output pc_o, 32 bits: the PC presented to decode (drives ID pc_i).
REQ-012 The block SHALL have output inst_o, 32 bits: the instruction presented to decode (drives ID inst_i).
REQ-013 The block SHALL have output valid_o, 1 bit: pc_o/inst_o hold a real instruction.
REQ-014 The block SHALL have output exc_adel_o, 1 bit: the presented slot carries a misaligned-fetch exception.

Function
REQ-015 Requests: imem_req_o and imem_addr_o SHALL stay stable from assertion until the cycle imem_ack_i=1.
REQ-016 FSM states SHALL be FETCH (req=1) and SKID (req=0); reset enters FETCH with imem_addr_o=RESET_PC.
REQ-017 An ack in FETCH with (valid_o=0 or stall_i=0) SHALL load pc_o=imem_addr_o, inst_o=imem_rdata_i, valid_o=1 at the next edge (1-cycle latency); the next request follows in that next cycle.
REQ-018 An ack in FETCH with valid_o=1 and stall_i=1 SHALL capture pc/data into a one-entry skid register and enter SKID.
REQ-019 In SKID with stall_i=0, the skid entry SHALL move to the output registers and the FSM SHALL return to FETCH.
REQ-020 With valid_o=1 and stall_i=1 the output registers SHALL hold unchanged.
REQ-021 With valid_o=1, stall_i=0 and no new data available, valid_o SHALL clear and inst_o SHALL become 32'h0 (NOP).
REQ-022 Next fetch address SHALL be imem_addr_o+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0) unless a redirect is pending.
REQ-023 branch_flag_i SHALL be honoured only when valid_o=1 and stall_i=0; the target SHALL be latched into a redirect register.
REQ-024 Delay slot: the fetch following the branch (branch PC+4) SHALL complete and be delivered; the fetch after it SHALL use the latched target, which then clears.
REQ-025 If branch_flag_i and imem_ack_i coincide, the ack'd word SHALL be the delay slot and the next request address SHALL be the target directly.
REQ-026 Throughput SHALL be one instruction per cycle when imem_ack_i is combinationally asserted and stall_i=0.

Reset
REQ-027 While rst=1: valid_o=0, pc_o=0, inst_o=0, exc_adel_o=0, skid empty, redirect cleared, imem_req_o=0.
REQ-028 rst mid-request SHALL abandon the request; an ack arriving during reset SHALL be ignored; the first request SHALL be issued at RESET_PC in the first cycle after rst falls.

Configuration
REQ-029 With macro IF_ADDR_ERR_EN defined, a redirect target with [1:0]!=0 SHALL issue no memory request and SHALL present valid_o=1, pc_o=target, inst_o=0, exc_adel_o=1; fetching then halts until rst.
REQ-030 Without IF_ADDR_ERR_EN, target bits [1:0] SHALL be forced to 2'b00 and exc_adel_o SHALL be tied 0.

Structure
REQ-031 RESET_PC default, the NOP word 32'h0 and the FSM state encodings SHALL live in the shared defines package used by ID.
REQ-032 The skid register SHALL be a sub-module named if_skid_buf (one entry: pc, inst, full flag).

Verification
REQ-033 Reset release with ack tied 1 -> imem_addr_o 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; pc_o follows one cycle later.
REQ-034 stall_i=1 for 3 cycles with ack=1 -> outputs hold, one word captured in SKID, req low; after release, no word is lost or duplicated.
REQ-035 Branch at 0x100 to 0x400 -> delivered PCs 0x100, 0x104, 0x400, 0x404.
REQ-036 Ack delayed 4 cycles during redirect -> addr stable while req is high; the delay slot is delivered before the target.
REQ-037 Fetch at 0xFFFFFFFC -> next request address 0x00000000.
REQ-038 IF_ADDR_ERR_EN defined, target 0x402 -> exc_adel_o=1, pc_o=0x402, no further imem_req_o; with the macro undefined -> fetch at 0x400.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch/decode definitions: reset vector, NOP encoding, fetch FSM states.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    SKID  = 1'b1
  } if_state_e;

  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_skid.sv
// if_skid_buf: one-entry holding register for a fetched word that decode could not take.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        full_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        full_q;
  logic [31:0] pc_q, inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      pc_q   <= 32'h0;
      inst_q <= NOP_INST;
    end else if (load_i) begin
      full_q <= 1'b1;
      pc_q   <= pc_i;
      inst_q <= inst_i;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one-entry skid buffer and delay-slot branch redirect.
// Build option IF_ADDR_ERR_EN: misaligned redirect targets raise a fetch address error and halt.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic        exc_adel_o
);

  if_state_e   state_q;
  logic [31:0] addr_q, pc_q, inst_q, redir_q;
  logic        valid_q, redir_vld_q, halt_q, exc_pend_q, exc_q;

  logic        accept, branch_take, fetch_ack, misal, skid_full;
  logic [31:0] tgt, addr_d, skid_pc, skid_inst;

  assign accept      = !valid_q || !stall_i;
  assign branch_take = valid_q && !stall_i && branch_flag_i;
  assign imem_req_o  = !rst && (state_q == FETCH) && !halt_q;
  assign fetch_ack   = imem_req_o && imem_ack_i;

`ifdef IF_ADDR_ERR_EN
  assign tgt   = branch_target_i;
  assign misal = |addr_d[1:0];
`else
  assign tgt   = branch_target_i & ~32'h3;
  assign misal = 1'b0;
`endif

  // A branch resolved this cycle beats a previously latched redirect, which beats sequential fetch.
  always_comb begin
    addr_d = next_word_addr(addr_q);
    if (branch_take)      addr_d = tgt;
    else if (redir_vld_q) addr_d = redir_q;
  end

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  ((state_q == FETCH) && fetch_ack && !accept),
    .clear_i ((state_q == SKID) && !stall_i),
    .pc_i    (addr_q),
    .inst_i  (imem_rdata_i),
    .full_o  (skid_full),
    .pc_o    (skid_pc),
    .inst_o  (skid_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      addr_q      <= RESET_PC;
      pc_q        <= 32'h0;
      inst_q      <= NOP_INST;
      valid_q     <= 1'b0;
      redir_q     <= 32'h0;
      redir_vld_q <= 1'b0;
      halt_q      <= 1'b0;
      exc_pend_q  <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (halt_q) begin
            // Halted: present the address-error slot once decode can take it, then freeze.
            if (exc_pend_q && accept) begin
              pc_q       <= addr_q;
              inst_q     <= NOP_INST;
              valid_q    <= 1'b1;
              exc_q      <= 1'b1;
              exc_pend_q <= 1'b0;
            end
          end else if (imem_ack_i) begin
            if (accept) begin
              pc_q    <= addr_q;
              inst_q  <= imem_rdata_i;
              valid_q <= 1'b1;
            end else begin
              state_q <= SKID;
            end
            addr_q      <= addr_d;
            redir_vld_q <= 1'b0;
            halt_q      <= misal;
            exc_pend_q  <= misal;
          end else begin
            if (valid_q && !stall_i) begin
              valid_q <= 1'b0;
              inst_q  <= NOP_INST;
            end
            if (branch_take) begin
              redir_q     <= tgt;
              redir_vld_q <= 1'b1;
            end
          end
        end
        SKID: begin
          // The skid entry is the delay slot of any branch resolved here, so redirect at once.
          if (!stall_i && skid_full) begin
            pc_q    <= skid_pc;
            inst_q  <= skid_inst;
            valid_q <= 1'b1;
            state_q <= FETCH;
            if (branch_take) begin
              addr_q     <= addr_d;
              halt_q     <= misal;
              exc_pend_q <= misal;
            end
          end
        end
      endcase
    end
  end

  assign imem_addr_o = addr_q;
  assign pc_o        = pc_q;
  assign inst_o      = inst_q;
  assign valid_o     = valid_q;
  assign exc_adel_o  = exc_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: program-order reference model plus directed literal sequences.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef IF_ADDR_ERR_EN
  localparam logic [31:0] TGT_B = 32'h0000_0400;
  localparam logic [31:0] TGT_C = 32'hFFFF_FFF8;
`else
  localparam logic [31:0] TGT_B = 32'h0000_0402;
  localparam logic [31:0] TGT_C = 32'hFFFF_FFFA;
`endif

  logic        clk = 1'b0;
  logic        rst, stall_i, branch_flag_i, ackEn;
  logic [31:0] branch_target_i;
  logic        imem_req_o, imem_ack_i, valid_o, exc_adel_o;
  logic [31:0] imem_addr_o, imem_rdata_i, pc_o, inst_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] consumed[$];
  logic [31:0] expSeq[$];

  logic [31:0] expPc, expFetch, mTgt, fSlot, fTgt, lastAcked;
  bit          mTgtPend = 1'b0;
  bit          fPend = 1'b0;
  bit          prevValid, prevStall, prevReq, prevAck;
  bit          prevRst = 1'b1;
  logic [31:0] prevPc, prevInst, prevAddr;
  logic [31:0] brPc[2], brTgt[2];
  bit          brArm[2];
  bit          randBr = 1'b0;
  bit          modelOff = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  assign imem_ack_i   = ackEn & imem_req_o;
  assign imem_rdata_i = memf(imem_addr_o);

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_rdata_i    (imem_rdata_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .valid_o         (valid_o),
    .exc_adel_o      (exc_adel_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkConsumed(input string name);
    checks++;
    if (consumed.size() < expSeq.size()) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d delivered expected at least %0d", name, consumed.size(), expSeq.size());
    end
    for (int i = 0; i < expSeq.size() && i < consumed.size(); i++)
      checkOutput($sformatf("%s[%0d]", name, i), consumed[i], expSeq[i]);
  endtask

  // Drives one cycle of inputs just after the rising edge; branches fire when their PC is presented.
  task automatic applyStimulus(input logic r, input logic s, input logic a);
    logic [31:0] rt;
    @(posedge clk);
    #2;
    rst = r;
    stall_i = s;
    ackEn = a;
    branch_flag_i = 1'b0;
    branch_target_i = $urandom;
    for (int k = 0; k < 2; k++)
      if (brArm[k] && valid_o && pc_o == brPc[k]) begin
        branch_flag_i = 1'b1;
        branch_target_i = brTgt[k];
      end
    if (randBr && !mTgtPend && valid_o && $urandom_range(0, 5) == 0) begin
      rt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
`ifdef IF_ADDR_ERR_EN
      rt = rt & 32'hFFFF_FFFC;
`endif
      branch_flag_i = 1'b1;
      branch_target_i = rt;
    end
  endtask

  task automatic resetDut();
    brArm[0] = 1'b0;
    brArm[1] = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    consumed.delete();
  endtask

  // Reference model: decode must see program order, memory must see the same order of fetches.
  always @(negedge clk) begin
    logic [31:0] p, t;
    if (!modelOff) begin
      if (rst) begin
        checkOutput("req_in_reset", 32'(imem_req_o), 32'd0);
        if (prevRst) begin
          checkOutput("valid_in_reset", 32'(valid_o), 32'd0);
          checkOutput("pc_in_reset", pc_o, 32'd0);
          checkOutput("inst_in_reset", inst_o, 32'd0);
          checkOutput("exc_in_reset", 32'(exc_adel_o), 32'd0);
        end
        expPc = RST_PC;
        expFetch = RST_PC;
        mTgtPend = 1'b0;
        fPend = 1'b0;
        lastAcked = 32'hFFFF_FFFF;
      end else begin
        if (!prevRst && prevValid && prevStall) begin
          checkOutput("hold_pc", pc_o, prevPc);
          checkOutput("hold_inst", inst_o, prevInst);
          checkOutput("hold_valid", 32'(valid_o), 32'd1);
        end
        if (!prevRst && prevReq && !prevAck) begin
          checkOutput("req_stable", 32'(imem_req_o), 32'd1);
          checkOutput("addr_stable", imem_addr_o, prevAddr);
        end
        checkOutput("exc_clear", 32'(exc_adel_o), 32'd0);
        if (valid_o) checkOutput("inst_word", inst_o, memf(pc_o));
        else         checkOutput("inst_nop", inst_o, 32'd0);
        if (valid_o && !stall_i) begin
          p = expPc;
          checkOutput("delivered_pc", pc_o, p);
          consumed.push_back(pc_o);
          if (mTgtPend) begin
            expPc = mTgt;
            mTgtPend = 1'b0;
          end else begin
            expPc = p + 32'd4;
          end
          if (branch_flag_i) begin
            t = branch_target_i & 32'hFFFF_FFFC;
            mTgtPend = 1'b1;
            mTgt = t;
            if (lastAcked == p + 32'd4) expFetch = t;
            else begin
              fPend = 1'b1;
              fSlot = p + 32'd4;
              fTgt = t;
            end
            for (int k = 0; k < 2; k++)
              if (brArm[k] && brPc[k] == p) brArm[k] = 1'b0;
          end
        end
        if (imem_req_o && imem_ack_i) begin
          checkOutput("fetch_addr", imem_addr_o, expFetch);
          lastAcked = expFetch;
          if (fPend && expFetch == fSlot) begin
            expFetch = fTgt;
            fPend = 1'b0;
          end else begin
            expFetch = expFetch + 32'd4;
          end
        end
      end
    end
    prevRst = rst;
    prevValid = valid_o;
    prevStall = stall_i;
    prevReq = imem_req_o;
    prevAck = imem_ack_i;
    prevPc = pc_o;
    prevInst = inst_o;
    prevAddr = imem_addr_o;
  end

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    branch_target_i = 32'h0;
    ackEn = 1'b0;
    brArm[0] = 1'b0;
    brArm[1] = 1'b0;

    // Reset release with ack tied high: one fetch per cycle, pc one cycle behind
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("a_rst_valid", 32'(valid_o), 32'd0);
    checkOutput("a_rst_req", 32'(imem_req_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("a_addr0", imem_addr_o, 32'hBFC0_0000);
    checkOutput("a_req0", 32'(imem_req_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("a_addr1", imem_addr_o, 32'hBFC0_0004);
    checkOutput("a_pc1", pc_o, 32'hBFC0_0000);
    checkOutput("a_valid1", 32'(valid_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("a_addr2", imem_addr_o, 32'hBFC0_0008);
    checkOutput("a_pc2", pc_o, 32'hBFC0_0004);
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("a_pc3", pc_o, 32'hBFC0_0008);

    // Reset in the middle of a request, with acks arriving during reset
    applyStimulus(1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("r_req", 32'(imem_req_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("r_valid", 32'(valid_o), 32'd0);
    checkOutput("r_pc", pc_o, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("r_addr", imem_addr_o, RST_PC);

    // Two chained branches with delay slots
    resetDut();
    brPc[0] = RST_PC;       brTgt[0] = 32'h0000_0100; brArm[0] = 1'b1;
    brPc[1] = 32'h0000_0100; brTgt[1] = TGT_B;        brArm[1] = 1'b1;
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
    expSeq = '{32'hBFC0_0000, 32'hBFC0_0004, 32'h0000_0100, 32'h0000_0104, 32'h0000_0400, 32'h0000_0404};
    checkConsumed("branch_seq");

    // Fetch address wraps past the top of the address space
    resetDut();
    brPc[0] = RST_PC; brTgt[0] = TGT_C; brArm[0] = 1'b1;
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
    expSeq = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    checkConsumed("wrap_seq");

    // Three-cycle stall with ack held high: one word parks in the skid entry
    resetDut();
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      #1;
      if (i > 0) begin
        checkOutput("s_req_low", 32'(imem_req_o), 32'd0);
        checkOutput("s_pc_hold", pc_o, 32'hBFC0_0008);
      end
    end
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1);
    expSeq = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_000C, 32'hBFC0_0010, 32'hBFC0_0014};
    checkConsumed("stall_seq");

    // Ack withheld for four cycles while a redirect is pending
    resetDut();
    brPc[0] = RST_PC; brTgt[0] = 32'h0000_0200; brArm[0] = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("d_req", 32'(imem_req_o), 32'd1);
      checkOutput("d_addr", imem_addr_o, 32'hBFC0_0004);
    end
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1);
    expSeq = '{32'hBFC0_0000, 32'hBFC0_0004, 32'h0000_0200, 32'h0000_0204};
    checkConsumed("delay_seq");

`ifdef IF_ADDR_ERR_EN
    // Misaligned redirect target: address error slot, no further requests
    modelOff = 1'b1;
    resetDut();
    brPc[0] = RST_PC; brTgt[0] = 32'h0000_0402; brArm[0] = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("e_req_off", 32'(imem_req_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      #1;
      checkOutput("e_exc", 32'(exc_adel_o), 32'd1);
      checkOutput("e_pc", pc_o, 32'h0000_0402);
      checkOutput("e_inst", inst_o, 32'd0);
      checkOutput("e_valid", 32'(valid_o), 32'd1);
      checkOutput("e_req", 32'(imem_req_o), 32'd0);
    end
    modelOff = 1'b0;
`endif

    // Randomized stalls, ack latency and branches, with one reset mid-run
    resetDut();
    randBr = 1'b1;
    for (int c = 0; c < 3000; c++)
      applyStimulus(c >= 1500 && c < 1502, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6);
    randBr = 1'b0;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
